// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared types and constants for the NOC output-port arbiter.
//   arb_state_t    - arbiter state (idle / locked to one wormhole packet)
//   PORT_N..PORT_L - router direction indices, NUM_DIRS directions in total
//   onehot_to_idx  - binary encode of a one-hot vector of up to 16 bits
package noc_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned PORT_N   = 0;
    localparam int unsigned PORT_S   = 1;
    localparam int unsigned PORT_W   = 2;
    localparam int unsigned PORT_E   = 3;
    localparam int unsigned PORT_L   = 4;
    localparam int unsigned NUM_DIRS = 5;

    // OR of the indices of all set bits; exact for a one-hot or zero input.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (onehot[i]) idx |= 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_ptr_pick.sv
// rr_ptr_pick: combinational rotating-priority pick.
//   req  in  NUM_PORTS  request vector
//   ptr  in  IDX_W      highest-priority port this cycle
//   gnt  out NUM_PORTS  one-hot winner (zero when no request)
//   idx  out IDX_W      binary winner index (zero when no request)
//   any  out 1          at least one request is set
// Implemented as a double-width masked priority encoder: the request vector is
// duplicated, bits below ptr are masked off, and the lowest set bit wins.
module rr_ptr_pick
    import noc_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_DIRS,
    parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    localparam int unsigned DW = 2 * NUM_PORTS;

    logic [DW-1:0] req_dbl;
    logic [DW-1:0] masked;
    logic          found;

    always_comb begin
        req_dbl = {req, req};
        // The upper copy supplies the wrapped-around ports ptr-1 .. 0.
        masked  = req_dbl & ({DW{1'b1}} << ptr);
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < int'(DW); i++) begin
            if (!found && masked[i]) begin
                found = 1'b1;
                if (i >= int'(NUM_PORTS)) idx = IDX_W'(i - int'(NUM_PORTS));
                else                      idx = IDX_W'(i);
            end
        end
        any = |req;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            gnt[k] = any && (idx == IDX_W'(k));
        end
    end

endmodule

// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: round-robin output-port arbiter with wormhole packet locking.
//   clk, rst_n   clock, asynchronous active-low reset
//   req_i        per-port request, held for the whole packet
//   tail_i       per-port tail-flit flag
//   ready_i      downstream accepts the granted flit
//   flush_i      synchronous abort of any lock
//   gnt_o        one-hot grant (crossbar select)
//   gnt_idx_o    binary grant index, 0 when nothing granted
//   gnt_valid_o  gnt_o is non-zero
//   locked_o     arbiter is locked to a packet owner
//   err_o        sticky protocol error (owner dropped req mid-packet)
// Optional: define NOC_RR_ARB_PERF_CNT_EN to add gnt_cnt_o, one saturating
// CNT_W-bit accepted-beat counter per port.
module noc_rr_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_DIRS,
    parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
`ifdef NOC_RR_ARB_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W     = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] tail_i,
    input  logic                 ready_i,
    input  logic                 flush_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic                 gnt_valid_o,
    output logic                 locked_o,
    output logic                 err_o
`ifdef NOC_RR_ARB_PERF_CNT_EN
    ,
    output logic [NUM_PORTS*CNT_W-1:0] gnt_cnt_o
`endif
);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic                 err_q, err_d;

    logic [NUM_PORTS-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 accept;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_PORTS - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_ptr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Grant outputs. Nothing is granted while reset is held, even though the
    // pick itself is combinational from req_i.
    always_comb begin
        gnt_o = '0;
        case (state_q)
            ARB_IDLE:   gnt_o = pick_gnt;
            ARB_LOCKED: gnt_o[owner_q] = req_i[owner_q];
        endcase
        gnt_o       = gnt_o & {NUM_PORTS{rst_n}};
        gnt_idx_o   = IDX_W'(onehot_to_idx(16'(gnt_o)));
        gnt_valid_o = |gnt_o;
        locked_o    = (state_q == ARB_LOCKED);
        err_o       = err_q;
        accept      = gnt_valid_o && ready_i;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        err_d   = err_q;
        if (flush_i) begin
            state_d = ARB_IDLE;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        if (accept && tail_i[pick_idx]) begin
                            ptr_d = next_ptr(pick_idx);
                        end else begin
                            // Lock even when not accepted so a backpressured
                            // grant cannot move on the next cycle.
                            state_d = ARB_LOCKED;
                            owner_d = pick_idx;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (!req_i[owner_q]) begin
                        err_d   = 1'b1;
                        state_d = ARB_IDLE;
                        ptr_d   = next_ptr(owner_q);
                    end else if (ready_i && tail_i[owner_q]) begin
                        state_d = ARB_IDLE;
                        ptr_d   = next_ptr(owner_q);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

`ifdef NOC_RR_ARB_PERF_CNT_EN
    for (genvar i = 0; i < int'(NUM_PORTS); i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (accept && gnt_o[i] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign gnt_cnt_o[i*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Bench for noc_rr_arbiter (NUM_PORTS=5): directed scenarios followed by random
// traffic, all checked against a behavioural round-robin/wormhole model.
module tb_noc_rr_arbiter;

    localparam int N     = 5;
    localparam int IW    = 3;
    localparam int CNT_W = 16;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  tail;
    logic          ready;
    logic          flush;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          locked;
    logic          err;
`ifdef NOC_RR_ARB_PERF_CNT_EN
    logic [N*CNT_W-1:0] gnt_cnt;
`endif

    noc_rr_arbiter #(
        .NUM_PORTS (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .tail_i      (tail),
        .ready_i     (ready),
        .flush_i     (flush),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid),
        .locked_o    (locked),
        .err_o       (err)
`ifdef NOC_RR_ARB_PERF_CNT_EN
        ,
        .gnt_cnt_o   (gnt_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit m_locked;
    int m_ptr;
    int m_owner;
    bit m_err;
    int m_cnt[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_ptr    = 0;
        m_owner  = 0;
        m_err    = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // First requesting port scanning upward from the pointer, modulo N.
    function automatic int model_pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check at the falling edge, advance model at the rising edge.
    // want: -2 no directed check, -1 expect no grant, >=0 expected granted port.
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] t, input logic rd,
                         input logic fl, input int want);
        int           w;
        logic [N-1:0] eg;
        logic [N-1:0] wg;
        bit           acc;
        req   = r;
        tail  = t;
        ready = rd;
        flush = fl;
        @(negedge clk);
        if (!m_locked) w = model_pick(r);
        else           w = r[m_owner] ? m_owner : -1;
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        check("gnt", 32'(gnt), 32'(eg));
        check("gnt_idx", 32'(gnt_idx), (w >= 0) ? w : 0);
        check("gnt_valid", 32'(gnt_valid), 32'(w >= 0));
        check("locked", 32'(locked), 32'(m_locked));
        check("err", 32'(err), 32'(m_err));
        if (want != -2) begin
            wg = '0;
            if (want >= 0) wg[want] = 1'b1;
            check("directed_gnt", 32'(gnt), 32'(wg));
        end
        @(posedge clk);
        acc = (w >= 0) && rd;
        if (acc && m_cnt[w] < (1 << CNT_W) - 1) m_cnt[w]++;
        if (fl) begin
            m_locked = 0;
        end else if (!m_locked) begin
            if (w >= 0) begin
                if (acc && t[w]) m_ptr = (w + 1) % N;
                else begin
                    m_locked = 1;
                    m_owner  = w;
                end
            end
        end else if (!r[m_owner]) begin
            m_err    = 1;
            m_locked = 0;
            m_ptr    = (m_owner + 1) % N;
        end else if (rd && t[m_owner]) begin
            m_locked = 0;
            m_ptr    = (m_owner + 1) % N;
        end
        #1;
    endtask

    initial begin
        logic [N-1:0] r;
        rst_n = 1'b0;
        req   = 5'b11111;
        tail  = 5'b00000;
        ready = 1'b0;
        flush = 1'b0;
        model_reset();

        // Reset held with all ports requesting: nothing granted.
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        check("rst_gnt_edge", 32'(gnt), 32'h0);
        rst_n = 1'b1;

        // Default pick then fairness sweep 0,1,2,3,4,0.
        cycle(5'b11111, 5'b11111, 1'b1, 1'b0, 0);
        for (int k = 1; k <= 5; k++) cycle(5'b11111, 5'b11111, 1'b1, 1'b0, k % 5);

        // Port 2 three-flit packet while port 0 keeps requesting.
        cycle(5'b00101, 5'b00000, 1'b1, 1'b0, 2);
        cycle(5'b00101, 5'b00000, 1'b1, 1'b0, 2);
        cycle(5'b00101, 5'b00100, 1'b1, 1'b0, 2);
        cycle(5'b00101, 5'b11111, 1'b1, 1'b0, 0);

        // Move ptr to 0, then backpressure on port 1.
        cycle(5'b10000, 5'b11111, 1'b1, 1'b0, 4);
        for (int k = 0; k < 4; k++) cycle(5'b01010, 5'b01010, 1'b0, 1'b0, 1);
        cycle(5'b01010, 5'b01010, 1'b1, 1'b0, 1);
        cycle(5'b01010, 5'b01010, 1'b1, 1'b0, 3);

        // Wrap from ptr=4.
        cycle(5'b01001, 5'b11111, 1'b1, 1'b0, 0);
        cycle(5'b01001, 5'b11111, 1'b1, 1'b0, 3);

        // Violation: port 1 locks then drops its request.
        cycle(5'b00010, 5'b00000, 1'b1, 1'b0, 1);
        cycle(5'b00000, 5'b00000, 1'b1, 1'b0, -1);
        cycle(5'b11111, 5'b11111, 1'b1, 1'b0, 2);
        check("err_sticky", 32'(err), 32'h1);

        // Flush while locked to port 0; beat in the flush cycle still counts.
        cycle(5'b00001, 5'b00000, 1'b1, 1'b0, 0);
        cycle(5'b00001, 5'b00000, 1'b1, 1'b1, 0);
        check("flush_unlock", 32'(locked), 32'h0);
        cycle(5'b00001, 5'b11111, 1'b1, 1'b0, 0);

        // Asynchronous reset mid-packet drops the lock and clears err.
        cycle(5'b00100, 5'b00000, 1'b1, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        check("midrst_gnt", 32'(gnt), 32'h0);
        check("midrst_locked", 32'(locked), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(5'b00100, 5'b11111, 1'b1, 1'b0, 2);

        // Random traffic; requests tend to persist so packets form.
        r = '0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
            cycle(r, N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), -2);
        end

`ifdef NOC_RR_ARB_PERF_CNT_EN
        for (int i = 0; i < N; i++) begin
            check("gnt_cnt", 32'(gnt_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
